// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract: W bits split into STAGES slices, one register per slice,
// with carry forwarding between stages and a bubble-collapsing valid/ready handshake.
module pipelined_ripple_adder #(
    parameter int W      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int SW = W / STAGES;

    // Returns {carry out, carry into top bit, slice sum}.
    function automatic logic [SW+1:0] ripple(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                             input logic ci);
        logic          c;
        logic          cm;
        logic [SW-1:0] s;
        c  = ci;
        cm = ci;
        s  = '0;
        for (int i = 0; i < SW; i++) begin
            cm   = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, cm, s};
    endfunction

    logic         v_q  [STAGES];
    logic [W-1:0] x_q  [STAGES];
    logic [W-1:0] y_q  [STAGES];
    logic [W-1:0] s_q  [STAGES];
    logic         c_q  [STAGES];
    logic         cm_q [STAGES];

    logic [STAGES-1:0] acc;
    logic [STAGES-1:0] adv;

    // Ready chain walks from the output back to the input; an empty stage always accepts.
    always_comb begin
        logic down;
        acc  = '0;
        adv  = '0;
        down = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = v_q[k] & down;
            acc[k] = !v_q[k] | adv[k];
            down   = acc[k];
        end
    end

    assign in_ready = acc[0] & ~rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0]  xi;
        logic [W-1:0]  yi;
        logic [W-1:0]  si;
        logic          ci;
        logic          vi;
        logic [SW+1:0] r;
        logic [W-1:0]  sn;

        if (k == 0) begin : g_first
            // Subtract is a + ~b + 1; cin only matters for add.
            assign xi = a;
            assign yi = sub ? ~b : b;
            assign ci = sub | cin;
            assign si = '0;
            assign vi = in_valid & in_ready;
        end else begin : g_next
            assign xi = x_q[k-1];
            assign yi = y_q[k-1];
            assign ci = c_q[k-1];
            assign si = s_q[k-1];
            assign vi = v_q[k-1];
        end

        assign r = ripple(xi[k*SW +: SW], yi[k*SW +: SW], ci);

        always_comb begin
            sn              = si;
            sn[k*SW +: SW]  = r[SW-1:0];
        end

        // Data only loads with a valid beat so the output holds through bubbles and stalls.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k]  <= 1'b0;
                x_q[k]  <= '0;
                y_q[k]  <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                cm_q[k] <= 1'b0;
            end else if (acc[k]) begin
                v_q[k] <= vi;
                if (vi) begin
                    x_q[k]  <= xi;
                    y_q[k]  <= yi;
                    s_q[k]  <= sn;
                    c_q[k]  <= r[SW+1];
                    cm_q[k] <= r[SW];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = c_q[STAGES-1] ^ cm_q[STAGES-1];

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the team's combinational ripple-carry adder.
- Splits a W-bit ripple-carry add/subtract into STAGES equal slices, with one register stage per slice; each slice's carry is forwarded to the next stage.
- Adds a subtract mode, signed-overflow and carry-out flags, and a bubble-collapsing valid/ready handshake, so it can sit in datapaths that need backpressure.
- Throughput is one operation per cycle when the pipeline is not stalled.

Parameters:
- W, 32, operand and result width; must be ≥ 2.
- STAGES, 4, number of pipeline stages and slices; W mod STAGES must be 0; STAGES ≥ 1.
- SW, W/STAGES, slice width; derived, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  W  operand X.
- b  in  W  operand Y.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1 = subtract (a - b); 0 = add (a + b + cin).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  W  result.
- cout  out  1  carry out of bit W-1 (for subtract, 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset
  - While rst=1 at a clock edge, all stage valids are cleared and all pipeline data registers are zeroed.
  - out_valid=0, sum=0, cout=0, ovf=0 after reset.
  - in_ready is forced to 0 while rst=1.
  - Reset mid-operation discards every in-flight beat. No partial result ever appears.
- Operand conditioning at acceptance
  - Y' = sub ? ~b : b.
  - c0 = sub ? 1 : cin; cin is ignored when sub=1.
- Slicing
  - Stage k (0..STAGES-1) computes bits [k*SW +: SW] of X + Y' using a ripple chain of full adders.
  - Stage k's carry-in is the carry registered from stage k-1; stage 0 uses c0.
  - Unprocessed upper operand bits travel down the pipeline alongside the data.
  - Already-computed lower sum bits are carried forward, so all of sum emerges aligned at the final stage.
- Flags
  - cout = C[W], the carry out of the MSB.
  - ovf = C[W] XOR C[W-1], where C[W-1] is the carry into the MSB.
  - Both flags are registered with the final stage.
- Handshake
  - Per-stage valid bits v[0..STAGES-1]; v[STAGES-1] drives out_valid.
  - Last stage accepts when !out_valid OR out_ready.
  - Stage k advances when v[k] AND stage k+1 accepts.
  - Stage k accepts when !v[k] OR stage k advances.
  - in_ready = stage 0 accepts. The ready chain is combinational from out_ready to in_ready.
  - A beat enters on in_valid AND in_ready.
  - Bubbles collapse: an empty stage always accepts regardless of downstream state.
- Latency and throughput
  - Exactly STAGES cycles from acceptance to out_valid, when unstalled.
  - Full throughput of one beat per cycle when out_ready is held at 1.
- Stall
  - While out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
  - Upstream stages fill until in_ready=0. Up to STAGES beats are buffered.
- Simultaneous events
  - Output pop and input push in the same cycle are both honoured; no beat is lost or duplicated.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Arithmetic
  - Results wrap modulo 2^W; no saturation.
  - in_valid=0 inputs are ignored: X/don't-care on a and b must not propagate into any valid result.

Test Plan (W=32, STAGES=4):
- Reset, then add a=0x0000_0001, b=0x0000_0002, cin=1, out_ready=1 → 4 cycles later sum=0x0000_0004, cout=0, ovf=0. in_ready=0 during rst.
- Carry across slice boundaries: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → sum=0, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, cout=0, ovf=1.
- Subtract: sub=1, a=5, b=7 → sum=0xFFFF_FFFE, cout=0, ovf=0. Then a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, cout=1, ovf=1. cin is toggled throughout with no effect.
- Backpressure: stream 10 beats with out_ready=0 → in_ready drops after 4 accepts and the held output is stable. Release out_ready → all 10 results emerge in order with no loss or duplication.
- Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 → results appear on the same cycle spacing, each 4 cycles after its input.
- Reset mid-flight: assert rst with 3 beats in flight → out_valid=0 and sum/cout/ovf=0 next cycle. No stale result ever appears after rst deasserts.
